// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone instruction-memory slave.
package wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WS_W   = 4;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        BURST
    } wb_slv_state_t;

endpackage

// File: rtl/wb_sp_ram.sv
// Synchronous single-port word RAM, one-cycle read latency, read-before-write.
module wb_sp_ram
    import wb_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register is reset so the bus data output starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone B4 word-memory slave: classic and incrementing-burst cycles,
// programmable wait states, and a preload port that forces bus retries.
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 1024,
    parameter  logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter  int unsigned WAIT_STATES = 0,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CYC,
    input  logic              STB,
    input  logic              WE,
    input  logic [31:0]       ADR,
    input  logic [DATA_W-1:0] DAT_I,
    input  logic [2:0]        CTI,
    output logic [DATA_W-1:0] DAT_O,
    output logic              ACK,
    output logic              ERR,
    output logic              RTY,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data
);

    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH_WORDS - 1);
    localparam logic [WS_W-1:0] WS_INIT  = WS_W'(WAIT_STATES);

    wb_slv_state_t     state_q, state_d;
    logic [WS_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              we_q, we_d;
    logic              ack_d, err_d, rty_d;
    logic              hold_v_q, hold_v_d;
    logic [AW-1:0]     hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;

    logic [31:0]       offset_c;
    logic              hit_c;
    logic [AW-1:0]     bus_idx_c;
    logic              req_c, term_c, beat_c, bus_own_c;
    logic              ram_we_c;
    logic [AW-1:0]     ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;

    assign offset_c  = ADR - BASE_ADDR;
    assign hit_c     = (ADR >= BASE_ADDR)
                    && ({2'b00, offset_c[31:2]} < 32'(DEPTH_WORDS))
                    && (offset_c[1:0] == 2'b00);
    assign bus_idx_c = offset_c[AW+1:2];
    assign req_c     = CYC && STB;
    // While a termination is on the bus the master's held request is ignored.
    assign term_c    = ACK || ERR || RTY;
    assign beat_c    = (state_q == RESP) || ((state_q == BURST) && ACK && req_c);
    assign bus_own_c = (state_q == RESP) || (state_q == BURST)
                    || ((state_q == WAIT) && (cnt_q <= WS_W'(1)))
                    || ((state_q == IDLE) && req_c && !term_c && !load_en);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_c && !term_c) begin
                    if (load_en) begin
                        rty_d = 1'b1;
                    end else if (!hit_c) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d = bus_idx_c;
                        we_d  = WE;
                        if (WAIT_STATES == 0) begin
                            state_d = RESP;
                            ack_d   = 1'b1;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = WS_INIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (!req_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= WS_W'(1)) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - WS_W'(1);
                end
            end
            RESP, BURST: begin
                if (beat_c) begin
                    if (req_c && (CTI == CTI_INCR)) begin
                        if (idx_q == LAST_IDX) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            ack_d   = 1'b1;
                            state_d = BURST;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!CYC) begin
                    state_d = IDLE;
                end else if (STB) begin
                    ack_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM port arbitration: bus beats first, then a held preload, then a live preload.
    always_comb begin
        ram_we_c    = 1'b0;
        ram_addr_c  = bus_idx_c;
        ram_wdata_c = DAT_I;
        hold_v_d    = hold_v_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        if (bus_own_c) begin
            if ((state_q == RESP) || (state_q == BURST)) begin
                ram_we_c   = beat_c && we_q;
                ram_addr_c = (beat_c && !we_q) ? idx_q + AW'(1) : idx_q;
            end else if (state_q == WAIT) begin
                ram_addr_c = idx_q;
            end
        end else if (hold_v_q) begin
            ram_we_c    = 1'b1;
            ram_addr_c  = hold_addr_q;
            ram_wdata_c = hold_data_q;
        end else if (load_en) begin
            ram_we_c    = 1'b1;
            ram_addr_c  = load_addr;
            ram_wdata_c = load_data;
        end
        if (load_en && (bus_own_c || hold_v_q)) begin
            hold_v_d    = 1'b1;
            hold_addr_d = load_addr;
            hold_data_d = load_data;
        end else if (!bus_own_c) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            ACK         <= 1'b0;
            ERR         <= 1'b0;
            RTY         <= 1'b0;
            hold_v_q    <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            ACK         <= ack_d;
            ERR         <= err_d;
            RTY         <= rty_d;
            hold_v_q    <= hold_v_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    wb_sp_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (ram_we_c),
        .addr (ram_addr_c),
        .wdata(ram_wdata_c),
        .rdata(DAT_O)
    );

endmodule
